// File: rtl/dds_pkg.sv
// Shared types and default widths for the RAM-DDS address/control stage.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } dds_state_e;

  localparam int ACC_W_DEF  = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with clear-on-start and phase-offset address adder.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [ACC_W-1:0]  ftw,
  input  logic [ADDR_W-1:0] pow,
  output logic [ADDR_W-1:0] addr
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] base;

  // clr makes the start cycle see a zero phase while idle cycles hold acc_q
  always_comb begin
    base  = clr ? '0 : acc_q;
    addr  = base[ACC_W-1 -: ADDR_W] + pow;
    acc_d = acc_q;
    if (adv) begin
      acc_d = base + ftw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dds_addr_gen.sv
// RAM-DDS address/control stage: table load, phase-driven
// reads and re-timing of RAM read data into a sample stream.
module dds_addr_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ACC_W-1:0]  ftw,
  input  logic [ADDR_W-1:0] pow,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy
);

  dds_state_e state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic              sv_q, sv_d;
  logic              avld_q, avld_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic              accept;
  logic              last;
  logic              start_run;
  logic              issue;
  logic              clr;
  logic [ADDR_W-1:0] acc_addr;

  assign accept    = (state_q == LOAD) && ld_valid;
  assign last      = accept && (cnt_q == '1);
  assign start_run = (state_q == IDLE) && en && !ld_start;
  assign issue     = start_run || ((state_q == RUN) && en);
  assign clr       = (state_q == IDLE);

  dds_phase_acc #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (issue),
    .ftw   (ftw),
    .pow   (pow),
    .addr  (acc_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      dina_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      smp_q   <= '0;
      sv_q    <= 1'b0;
      avld_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      dina_q  <= dina_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      smp_q   <= smp_d;
      sv_q    <= sv_d;
      avld_q  <= avld_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
        end else if (en) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (last) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    wea_d  = 1'b0;
    addr_d = addr_q;
    dina_d = dina_q;
    done_d = last;
    busy_d = (state_d != IDLE);
    avld_d = issue;
    smp_d  = smp_q;
    sv_d   = vld_q[RD_LAT-1];

    unique case (1'b1)
      accept: begin
        wea_d  = 1'b1;
        addr_d = cnt_q;
        dina_d = ld_data;
        cnt_d  = cnt_q + ADDR_W'(1);
      end
      issue: begin
        addr_d = acc_addr;
      end
      default: ;
    endcase

    // avld_q is aligned with addra; vld_q adds the RAM read latency
    vld_d[0] = avld_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    if (vld_q[RD_LAT-1]) begin
      smp_d = douta;
    end
  end

  assign ld_ready     = (state_q == LOAD);
  assign ld_done      = done_q;
  assign wea          = wea_q;
  assign addra        = addr_q;
  assign dina         = dina_q;
  assign sample       = smp_q;
  assign sample_valid = sv_q;
  assign busy         = busy_q;

endmodule
